complex_unit_scheduler: RTL and testbench

Shares one non-pipelined, fixed-latency complex execution unit (divide/long-multiply class) between `LANES` issue lanes. Each lane's complex-routed packet output is a requester. The block arbitrates round-robin, sequences the unit through start, latency count and result capture, holds the result until writeback accepts it, and aborts cleanly on pipeline recovery. It sits between the per-lane complex/simple packet demultiplexers and the shared complex unit.

---
 rtl/complex_unit_scheduler.sv | 141 ++++++++++++++
 tb/tb_complex_unit_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/complex_unit_scheduler.sv
// complex_unit_scheduler
// Round-robin arbiter and sequencer that shares one fixed-latency, non-pipelined
// complex execution unit between LANES issue lanes. A granted packet is held
// for the whole operation, the result is captured LAT cycles after the start
// pulse and then held until writeback takes it. A flush aborts whatever is held
// or in flight and returns the block to IDLE.
module complex_unit_scheduler #(
  parameter int LANES  = 2,
  parameter int PKT_W  = 128,
  parameter int DATA_W = 64,
  parameter int LAT    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [LANES-1:0]       req_valid,
  input  logic [LANES*PKT_W-1:0] req_pkt,
  output logic [LANES-1:0]       req_ready,
  output logic                   unit_start,
  output logic                   unit_kill,
  output logic [PKT_W-1:0]       unit_pkt,
  input  logic [DATA_W-1:0]      unit_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PKT_W-1:0]       out_pkt,
  output logic [DATA_W-1:0]      out_result,
  output logic                   busy
);

  localparam int CNT_W = $clog2(LAT + 1);
  localparam int PTR_W = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PKT_W-1:0]   r_hold_pkt;
  logic [DATA_W-1:0]  r_hold_res;

  logic [PKT_W-1:0]   w_pkts [LANES];
  logic [PTR_W-1:0]   w_lane;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_grant_any;
  logic               w_take;
  logic               w_capture;

  // Split the flat packet bus into one entry per lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_unpack
    assign w_pkts[gi] = req_pkt[gi*PKT_W +: PKT_W];
  end

  // Round-robin pick: first valid lane at or above rr_ptr, wrapping around.
  // NOTE: every variable written in a combinational block gets a default at the
  // top, otherwise paths that skip an assignment infer a latch.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_lane      = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane = PTR_W'((int'(r_rr_ptr) + i) % LANES);
      if (!w_grant_any && req_valid[w_lane]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_lane;
      end
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state and combinational handshake outputs; flush overrides all.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    unit_start  = 1'b0;
    unit_kill   = 1'b0;
    out_valid   = 1'b0;
    w_take      = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!flush && w_grant_any) begin
          req_ready[w_grant_idx] = 1'b1;
          w_take                 = 1'b1;
          w_state_nxt            = S_BUSY;
        end
      end
      S_BUSY: begin
        unit_start = (r_cnt == CNT_W'(LAT));
        unit_kill  = flush;
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = !flush;
        if (flush || out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the granted packet, run the latency counter, capture result.
  // NOTE: the held packet and result are reset as well, so the outputs read as
  // zero out of reset rather than carrying whatever powered up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_hold_pkt <= '0;
      r_hold_res <= '0;
    end else if (w_take) begin
      r_hold_pkt <= w_pkts[w_grant_idx];
      r_cnt      <= CNT_W'(LAT);
      r_rr_ptr   <= PTR_W'((int'(w_grant_idx) + 1) % LANES);
    end else if (r_state == S_BUSY) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_capture)   r_hold_res <= unit_result;
    end
  end

  assign unit_pkt   = r_hold_pkt;
  assign out_pkt    = r_hold_pkt;
  assign out_result = r_hold_res;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_complex_unit_scheduler.sv
// Randomized self-checking bench for complex_unit_scheduler. A transaction-level
// model tracks the one op in flight by its age since grant and predicts every
// output each cycle.
module tb_complex_unit_scheduler;

  localparam int LANES  = 2;
  localparam int PKT_W  = 32;
  localparam int DATA_W = 16;
  localparam int LAT    = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   flush;
  logic [LANES-1:0]       req_valid;
  logic [LANES*PKT_W-1:0] req_pkt;
  logic [LANES-1:0]       req_ready;
  logic                   unit_start;
  logic                   unit_kill;
  logic [PKT_W-1:0]       unit_pkt;
  logic [DATA_W-1:0]      unit_result;
  logic                   out_valid;
  logic                   out_ready;
  logic [PKT_W-1:0]       out_pkt;
  logic [DATA_W-1:0]      out_result;
  logic                   busy;

  complex_unit_scheduler #(
    .LANES(LANES), .PKT_W(PKT_W), .DATA_W(DATA_W), .LAT(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_pkt(req_pkt), .req_ready(req_ready),
    .unit_start(unit_start), .unit_kill(unit_kill), .unit_pkt(unit_pkt),
    .unit_result(unit_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_pkt(out_pkt), .out_result(out_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Lane-side stimulus state: a valid lane keeps its packet until granted.
  logic [LANES-1:0]  lane_vld;
  logic [PKT_W-1:0]  lane_pkt [LANES];

  // Reference model: one op, described by its age in cycles since grant.
  bit                m_active;
  bit                m_done;
  int                m_age;
  int                m_ptr;
  logic [PKT_W-1:0]  m_pkt;
  logic [DATA_W-1:0] m_res;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic pack_inputs();
    req_valid = lane_vld;
    for (int l = 0; l < LANES; l++) req_pkt[l*PKT_W +: PKT_W] = lane_pkt[l];
  endtask

  task automatic drive_random(input bit allow_flush, input bit force_all);
    for (int l = 0; l < LANES; l++) begin
      if (!lane_vld[l] && (force_all || $urandom_range(0, 1) == 1)) begin
        lane_vld[l] = 1'b1;
        lane_pkt[l] = $urandom;
      end
    end
    pack_inputs();
    flush       = allow_flush && ($urandom_range(0, 15) == 0);
    out_ready   = ($urandom_range(0, 3) != 0);
    unit_result = DATA_W'($urandom);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_age    = 0;
    m_ptr    = 0;
    m_pkt    = '0;
    m_res    = '0;
  endtask

  // Called at posedge+1 with inputs applied: check mid-cycle, advance model, clock.
  task automatic step();
    int g;
    logic [LANES-1:0] exp_ready;
    #4;
    g = -1;
    exp_ready = '0;
    if (!m_active && !flush) begin
      for (int k = 0; k < LANES; k++) begin
        int l;
        l = (m_ptr + k) % LANES;
        if (g < 0 && req_valid[l]) g = l;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;

    check("req_ready",  64'(req_ready),  64'(exp_ready));
    check("unit_start", 64'(unit_start), 64'(m_active && !m_done && m_age == 1));
    check("unit_kill",  64'(unit_kill),  64'(flush && m_active && !m_done));
    check("out_valid",  64'(out_valid),  64'(m_done && !flush));
    check("busy",       64'(busy),       64'(m_active));
    if (m_active) begin
      check("unit_pkt", 64'(unit_pkt), 64'(m_pkt));
      check("out_pkt",  64'(out_pkt),  64'(m_pkt));
    end
    if (m_done) check("out_result", 64'(out_result), 64'(m_res));

    if (flush) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (!m_active) begin
      if (g >= 0) begin
        m_active    = 1'b1;
        m_age       = 1;
        m_pkt       = lane_pkt[g];
        m_ptr       = (g + 1) % LANES;
        lane_vld[g] = 1'b0;
      end
    end else if (!m_done) begin
      if (m_age == LAT + 1) begin
        m_res  = unit_result;
        m_done = 1'b1;
      end
      m_age++;
    end else if (out_ready) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    reset_n     = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    unit_result = '0;
    lane_vld    = '0;
    for (int l = 0; l < LANES; l++) lane_pkt[l] = '0;
    pack_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;

    check("rst_busy",       64'(busy),       64'(0));
    check("rst_req_ready",  64'(req_ready),  64'(0));
    check("rst_unit_start", 64'(unit_start), 64'(0));
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_out_pkt",    64'(out_pkt),    64'(0));
    check("rst_out_result", 64'(out_result), 64'(0));
    @(posedge clk);
    #1;

    // Phase 1: random traffic with flushes and writeback backpressure.
    for (int c = 0; c < 1500; c++) begin
      drive_random(1'b1, 1'b0);
      step();
    end

    // Phase 2: reach mid-BUSY with rr_ptr pointing at lane 1, then reset.
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (m_active && !m_done && m_age >= 2 && m_ptr == 1) begin
        found = 1'b1;
      end else begin
        drive_random(1'b0, 1'b0);
        step();
      end
    end
    check("reset_window_found", 64'(found), 64'(1));

    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy",       64'(busy),       64'(0));
    check("async_rst_unit_start", 64'(unit_start), 64'(0));
    check("async_rst_out_valid",  64'(out_valid),  64'(0));
    check("async_rst_out_pkt",    64'(out_pkt),    64'(0));
    check("async_rst_out_result", 64'(out_result), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Both lanes pending: the model expects lane 0 first since rr_ptr resets to 0.
    drive_random(1'b0, 1'b1);
    step();

    // Phase 3: more random traffic after reset.
    for (int c = 0; c < 600; c++) begin
      drive_random(1'b1, 1'b0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
